// File: rtl/lifo32_ctrl.sv
// 32-deep LIFO controller driving WIDTH parallel 32x1 single-port RAM cells.
// Optional zero-fill scrub of the RAM after reset and after CLEAR.
module lifo32_ctrl #(
  parameter int WIDTH = 8,
  parameter bit SCRUB = 1'b1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CLEAR,
  input  logic             PUSH_VLD,
  input  logic [WIDTH-1:0] PUSH_DATA,
  output logic             PUSH_RDY,
  input  logic             POP_REQ,
  output logic [WIDTH-1:0] POP_DATA,
  output logic             POP_VLD,
  output logic [5:0]       COUNT,
  output logic             FULL,
  output logic             EMPTY,
  output logic             BUSY,
  output logic             OVF,
  output logic             UDF,
  output logic             RAM_WE,
  output logic [4:0]       RAM_A,
  output logic [WIDTH-1:0] RAM_D,
  input  logic [WIDTH-1:0] RAM_O
);

  typedef enum logic {ST_SCRUB, ST_RUN} state_t;

  localparam state_t INIT_STATE = SCRUB ? ST_SCRUB : ST_RUN;

  state_t     state, state_nxt;
  logic [4:0] scrub_cnt;
  logic [4:0] rd_addr;
  logic       run, push_ok, pop_ok;

  assign run     = (state == ST_RUN);
  assign FULL    = (COUNT == 6'd32);
  assign EMPTY   = (COUNT == 6'd0);
  assign BUSY    = ~run;
  assign rd_addr = COUNT[4:0] - 5'd1;

  // A push into a full stack is legal when a pop empties the top in the same cycle.
  assign push_ok  = run & PUSH_VLD & (~FULL | POP_REQ);
  assign pop_ok   = run & POP_REQ & (~EMPTY | PUSH_VLD);
  assign PUSH_RDY = push_ok;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= INIT_STATE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (CLEAR)
      state_nxt = INIT_STATE;
    else if (state == ST_SCRUB && scrub_cnt == 5'd31)
      state_nxt = ST_RUN;
  end

  // RAM write enable is gated by RST_N so nothing is written while reset is held.
  always_comb begin
    RAM_WE = 1'b0;
    RAM_A  = rd_addr;
    RAM_D  = PUSH_DATA;
    if (state == ST_SCRUB) begin
      RAM_WE = RST_N;
      RAM_A  = scrub_cnt;
      RAM_D  = '0;
    end else if (push_ok && !pop_ok && !CLEAR) begin
      RAM_WE = RST_N;
      RAM_A  = COUNT[4:0];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      scrub_cnt <= '0;
      COUNT     <= '0;
      POP_DATA  <= '0;
      POP_VLD   <= 1'b0;
      OVF       <= 1'b0;
      UDF       <= 1'b0;
    end else if (CLEAR) begin
      scrub_cnt <= '0;
      COUNT     <= '0;
      POP_VLD   <= 1'b0;
      OVF       <= 1'b0;
      UDF       <= 1'b0;
    end else begin
      POP_VLD <= 1'b0;
      if (state == ST_SCRUB) begin
        scrub_cnt <= scrub_cnt + 5'd1;
      end else begin
        if (push_ok && pop_ok) begin
          POP_DATA <= PUSH_DATA;
          POP_VLD  <= 1'b1;
        end else if (push_ok) begin
          COUNT <= COUNT + 6'd1;
        end else if (pop_ok) begin
          POP_DATA <= RAM_O;
          POP_VLD  <= 1'b1;
          COUNT    <= COUNT - 6'd1;
        end
        if (PUSH_VLD && !push_ok) OVF <= 1'b1;
        if (POP_REQ && !pop_ok)   UDF <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lifo32_ctrl.sv
// Directed bench for lifo32_ctrl with a behavioural 32xWIDTH RAM and a popped-data scoreboard.
module tb_lifo32_ctrl;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         CLEAR;
  logic         PUSH_VLD;
  logic [W-1:0] PUSH_DATA;
  logic         PUSH_RDY;
  logic         POP_REQ;
  logic [W-1:0] POP_DATA;
  logic         POP_VLD;
  logic [5:0]   COUNT;
  logic         FULL, EMPTY, BUSY, OVF, UDF;
  logic         RAM_WE;
  logic [4:0]   RAM_A;
  logic [W-1:0] RAM_D;
  logic [W-1:0] RAM_O;

  logic [W-1:0] mem [32];
  logic [W-1:0] exp_q [$];
  int           total = 0;
  int           passed = 0;

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (RAM_WE) mem[RAM_A] <= RAM_D;
  assign RAM_O = mem[RAM_A];

  lifo32_ctrl #(.WIDTH(W), .SCRUB(1'b1)) dut (
    .CLK(CLK), .RST_N(RST_N), .CLEAR(CLEAR),
    .PUSH_VLD(PUSH_VLD), .PUSH_DATA(PUSH_DATA), .PUSH_RDY(PUSH_RDY),
    .POP_REQ(POP_REQ), .POP_DATA(POP_DATA), .POP_VLD(POP_VLD),
    .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY), .BUSY(BUSY), .OVF(OVF), .UDF(UDF),
    .RAM_WE(RAM_WE), .RAM_A(RAM_A), .RAM_D(RAM_D), .RAM_O(RAM_O)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every POP_VLD strobe must match the oldest expected word.
  always @(negedge CLK) begin
    if (RST_N && POP_VLD) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL pop_unexpected: got POP_DATA 0x%0h with nothing expected", POP_DATA);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (POP_DATA === e) passed++;
        else $display("FAIL pop_data: got 0x%0h expected 0x%0h", POP_DATA, e);
      end
    end
  end

  task automatic drive(input logic pv, input logic [W-1:0] pd, input logic pr);
    PUSH_VLD = pv; PUSH_DATA = pd; POP_REQ = pr;
    @(posedge CLK); #1;
    PUSH_VLD = 1'b0; POP_REQ = 1'b0;
  endtask

  task automatic scrub_check(input string name);
    for (int i = 0; i < 32; i++) begin
      @(negedge CLK);
      check(name, {RAM_WE, BUSY, PUSH_RDY, RAM_A, RAM_D}, {1'b1, 1'b1, 1'b0, 5'(i), 8'h00});
      @(posedge CLK);
    end
    #1;
  endtask

  task automatic check_mem_zero(input string name);
    int bad = 0;
    for (int i = 0; i < 32; i++) if (mem[i] !== '0) bad++;
    check(name, bad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    RST_N = 1'b0; CLEAR = 1'b0; PUSH_VLD = 1'b0; PUSH_DATA = '0; POP_REQ = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    PUSH_VLD = 1'b1; POP_REQ = 1'b1;
    check("reset_state", {COUNT, POP_DATA, POP_VLD, OVF, UDF, RAM_WE, BUSY},
          {6'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    RST_N = 1'b1;

    // Scrub after reset release, with requests held high to prove they are ignored.
    scrub_check("scrub_after_reset");
    PUSH_VLD = 1'b0; POP_REQ = 1'b0;
    check("run_after_scrub", {BUSY, OVF, UDF, EMPTY}, {1'b0, 1'b0, 1'b0, 1'b1});
    check_mem_zero("mem_zero_after_scrub");

    // Basic LIFO ordering.
    drive(1'b1, 8'h11, 1'b0);
    drive(1'b1, 8'h22, 1'b0);
    drive(1'b1, 8'h33, 1'b0);
    check("count_after_3_push", COUNT, 6'd3);
    exp_q.push_back(8'h33); drive(1'b0, '0, 1'b1);
    exp_q.push_back(8'h22); drive(1'b0, '0, 1'b1);
    exp_q.push_back(8'h11); drive(1'b0, '0, 1'b1);
    @(negedge CLK);
    check("empty_after_pops", {COUNT, EMPTY}, {6'd0, 1'b1});

    // Fill to 32, overflow, bypass at full, then drain.
    for (int i = 0; i < 32; i++) drive(1'b1, 8'(i + 1), 1'b0);
    check("full_at_32", {COUNT, FULL, OVF}, {6'd32, 1'b1, 1'b0});
    PUSH_VLD = 1'b1; PUSH_DATA = 8'hEE; #1;
    check("push_rdy_low_full", PUSH_RDY, 1'b0);
    @(posedge CLK); #1;
    PUSH_VLD = 1'b0;
    check("ovf_at_full", {OVF, COUNT}, {1'b1, 6'd32});
    PUSH_VLD = 1'b1; PUSH_DATA = 8'hAA; POP_REQ = 1'b1; #1;
    check("bypass_full_rdy_we", {PUSH_RDY, RAM_WE}, {1'b1, 1'b0});
    exp_q.push_back(8'hAA);
    @(posedge CLK); #1;
    PUSH_VLD = 1'b0; POP_REQ = 1'b0;
    check("bypass_full_count", COUNT, 6'd32);
    for (int i = 32; i >= 1; i--) begin
      exp_q.push_back(8'(i));
      drive(1'b0, '0, 1'b1);
    end
    check("drained", {COUNT, EMPTY, UDF}, {6'd0, 1'b1, 1'b0});

    // Underflow and bypass at empty.
    drive(1'b0, '0, 1'b1);
    check("udf_at_empty", {UDF, COUNT}, {1'b1, 6'd0});
    exp_q.push_back(8'h5C);
    drive(1'b1, 8'h5C, 1'b1);
    check("bypass_empty_count", COUNT, 6'd0);

    // CLEAR beats a push at COUNT=5 and restarts scrub.
    for (int i = 0; i < 5; i++) drive(1'b1, 8'hC0 + 8'(i), 1'b0);
    check("count_5", COUNT, 6'd5);
    CLEAR = 1'b1; PUSH_VLD = 1'b1; PUSH_DATA = 8'h99; #1;
    check("clear_no_we", RAM_WE, 1'b0);
    @(posedge CLK); #1;
    CLEAR = 1'b0; PUSH_VLD = 1'b0;
    check("after_clear", {COUNT, OVF, UDF, BUSY, POP_VLD}, {6'd0, 1'b0, 1'b0, 1'b1, 1'b0});
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("scrub_partial", {RAM_WE, RAM_A}, {1'b1, 5'(i)});
      @(posedge CLK);
    end
    #1;
    RST_N = 1'b0; #1;
    check("reset_mid_scrub", {RAM_WE, BUSY, COUNT}, {1'b0, 1'b1, 6'd0});
    #2;
    RST_N = 1'b1;
    scrub_check("scrub_restart");
    check_mem_zero("mem_zero_after_rescrub");

    drive(1'b1, 8'h77, 1'b0);
    exp_q.push_back(8'h77);
    drive(1'b0, '0, 1'b1);
    repeat (2) @(posedge CLK);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
